counter_mod_param: RTL and testbench

- Parametrised successor to the fixed 6-bit modulo counter; default configuration is a 6-bit mod-60 counter.
- Generalises width and modulus.
- Adds up/down direction, synchronous clear, parallel load, and wrap or saturate mode.
- Provides a cascade carry (tc) for chaining counters, e.g. sec->min->hour, plus a one-cycle wrap pulse and a sticky overflow flag.

---
 rtl/counter_mod_param_if.sv | 26 ++
 rtl/counter_mod_param.sv | 92 +++++++++
 tb/tb_counter_mod_param.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/counter_mod_param_if.sv
// Control/status bundle for counter_mod_param.
// The master drives the controls; the slave (the counter) drives count and status.
interface counter_mod_param_if #(
    parameter int WIDTH = 6
);
    logic             en;
    logic             up;
    logic             sat;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;
    logic             ovf;

    modport master (
        output en, up, sat, clr, load, load_val,
        input  count, tc, wrap, ovf
    );

    modport slave (
        input  en, up, sat, clr, load, load_val,
        output count, tc, wrap, ovf
    );
endinterface

// File: rtl/counter_mod_param.sv
// Parametrised modulo counter with up/down direction, wrap or saturate,
// synchronous clear and load, cascade terminal count, wrap pulse and sticky overflow.
module counter_mod_param #(
    parameter int WIDTH   = 6,
    parameter int MODULUS = 60,
    parameter int RST_VAL = 0
) (
    input  logic              clk,
    input  logic              rst,
    counter_mod_param_if.slave bus
);

    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
        $error("counter_mod_param: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end
    if (RST_VAL < 0 || RST_VAL >= MODULUS) begin : g_bad_rst_val
        $error("counter_mod_param: RST_VAL must be in 0..MODULUS-1");
    end

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RST_VAL);
    // One extra bit so MODULUS == 2**WIDTH is representable for the load range check.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic             r_ovf;

    logic             w_at_max;
    logic             w_at_zero;
    logic             w_at_end;
    logic             w_load_ok;
    logic [WIDTH-1:0] w_step;

    assign w_at_max  = (r_count == MAX_VAL);
    assign w_at_zero = (r_count == '0);
    assign w_at_end  = bus.up ? w_at_max : w_at_zero;
    assign w_load_ok = ({1'b0, bus.load_val} < MOD_EXT);

    // Next value for an enabled step; at the range ends this is the wrapped value,
    // so count never passes through anything >= MODULUS.
    always_comb begin
        w_step = r_count;
        if (bus.up) begin
            w_step = w_at_max ? '0 : r_count + WIDTH'(1);
        end else begin
            w_step = w_at_zero ? MAX_VAL : r_count - WIDTH'(1);
        end
    end

    // Count, wrap pulse and sticky overflow, priority rst > clr > load > en > hold.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= RST_CNT;
            r_wrap  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (bus.clr) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (bus.load) begin
            // Out-of-range load clamps to the top of the range and flags overflow.
            r_count <= w_load_ok ? bus.load_val : MAX_VAL;
            r_wrap  <= 1'b0;
            if (!w_load_ok) begin
                r_ovf <= 1'b1;
            end
        end else if (bus.en) begin
            if (w_at_end) begin
                r_ovf <= 1'b1;
                if (bus.sat) begin
                    r_wrap <= 1'b0;
                end else begin
                    r_count <= w_step;
                    r_wrap  <= 1'b1;
                end
            end else begin
                r_count <= w_step;
                r_wrap  <= 1'b0;
            end
        end else begin
            r_wrap <= 1'b0;
        end
    end

    // Terminal count is combinational so it can enable the next stage in the same cycle.
    assign bus.tc    = bus.en & w_at_end;
    assign bus.count = r_count;
    assign bus.wrap  = r_wrap;
    assign bus.ovf   = r_ovf;

endmodule

// File: tb/tb_counter_mod_param.sv
// Bench for counter_mod_param: directed scenarios plus random stimulus, all
// checked every cycle against an arithmetic reference model.
// Instances: 0 = 6b/mod60, 1 = 4b/mod16 (RST_VAL 5), 2 = 4b/mod10,
// 3 and 4 = cascaded 6b/mod60 pair (tc of 3 drives en of 4).
module tb_counter_mod_param;

    localparam int N = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    counter_mod_param_if #(.WIDTH(6)) if_a ();
    counter_mod_param_if #(.WIDTH(4)) if_b ();
    counter_mod_param_if #(.WIDTH(4)) if_c ();
    counter_mod_param_if #(.WIDTH(6)) if_k0 ();
    counter_mod_param_if #(.WIDTH(6)) if_k1 ();

    counter_mod_param #(.WIDTH(6), .MODULUS(60), .RST_VAL(0)) u_a  (.clk(clk), .rst(rst), .bus(if_a));
    counter_mod_param #(.WIDTH(4), .MODULUS(16), .RST_VAL(5)) u_b  (.clk(clk), .rst(rst), .bus(if_b));
    counter_mod_param #(.WIDTH(4), .MODULUS(10), .RST_VAL(0)) u_c  (.clk(clk), .rst(rst), .bus(if_c));
    counter_mod_param #(.WIDTH(6), .MODULUS(60), .RST_VAL(0)) u_k0 (.clk(clk), .rst(rst), .bus(if_k0));
    counter_mod_param #(.WIDTH(6), .MODULUS(60), .RST_VAL(0)) u_k1 (.clk(clk), .rst(rst), .bus(if_k1));

    // Stimulus per instance
    logic       in_en   [N];
    logic       in_up   [N];
    logic       in_sat  [N];
    logic       in_clr  [N];
    logic       in_load [N];
    logic [5:0] in_lv   [N];

    assign if_a.en  = in_en[0];  assign if_a.up  = in_up[0];  assign if_a.sat  = in_sat[0];
    assign if_a.clr = in_clr[0]; assign if_a.load = in_load[0]; assign if_a.load_val = in_lv[0];
    assign if_b.en  = in_en[1];  assign if_b.up  = in_up[1];  assign if_b.sat  = in_sat[1];
    assign if_b.clr = in_clr[1]; assign if_b.load = in_load[1]; assign if_b.load_val = in_lv[1][3:0];
    assign if_c.en  = in_en[2];  assign if_c.up  = in_up[2];  assign if_c.sat  = in_sat[2];
    assign if_c.clr = in_clr[2]; assign if_c.load = in_load[2]; assign if_c.load_val = in_lv[2][3:0];
    assign if_k0.en  = in_en[3];  assign if_k0.up  = in_up[3];  assign if_k0.sat  = in_sat[3];
    assign if_k0.clr = in_clr[3]; assign if_k0.load = in_load[3]; assign if_k0.load_val = in_lv[3];
    assign if_k1.en  = if_k0.tc;  assign if_k1.up  = in_up[4];  assign if_k1.sat  = in_sat[4];
    assign if_k1.clr = in_clr[4]; assign if_k1.load = in_load[4]; assign if_k1.load_val = in_lv[4];

    // Observed outputs
    logic [5:0] o_cnt  [N];
    logic       o_tc   [N];
    logic       o_wrap [N];
    logic       o_ovf  [N];

    assign o_cnt[0] = if_a.count;          assign o_tc[0] = if_a.tc;  assign o_wrap[0] = if_a.wrap;  assign o_ovf[0] = if_a.ovf;
    assign o_cnt[1] = {2'b00, if_b.count}; assign o_tc[1] = if_b.tc;  assign o_wrap[1] = if_b.wrap;  assign o_ovf[1] = if_b.ovf;
    assign o_cnt[2] = {2'b00, if_c.count}; assign o_tc[2] = if_c.tc;  assign o_wrap[2] = if_c.wrap;  assign o_ovf[2] = if_c.ovf;
    assign o_cnt[3] = if_k0.count;         assign o_tc[3] = if_k0.tc; assign o_wrap[3] = if_k0.wrap; assign o_ovf[3] = if_k0.ovf;
    assign o_cnt[4] = if_k1.count;         assign o_tc[4] = if_k1.tc; assign o_wrap[4] = if_k1.wrap; assign o_ovf[4] = if_k1.ovf;

    // Reference model state
    int m_mod  [N] = '{60, 16, 10, 60, 60};
    int m_rv   [N] = '{0, 5, 0, 0, 0};
    int m_mask [N] = '{63, 15, 15, 63, 63};
    int m_cnt  [N];
    bit m_wrap [N];
    bit m_ovf  [N];
    bit m_valid = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic set_all(input bit en, input bit up, input bit sat,
                           input bit clr, input bit load, input int lv);
        for (int i = 0; i < N; i++) begin
            in_en[i]   = en;
            in_up[i]   = up;
            in_sat[i]  = sat;
            in_clr[i]  = clr;
            in_load[i] = load;
            in_lv[i]   = 6'(lv);
        end
    endtask

    // One clock: check tc before the edge, advance the model at the edge,
    // check registered outputs just after it.
    task automatic tick();
        bit en_eff [N];
        bit tc_exp [N];
        #1;
        for (int i = 0; i < N; i++) begin
            en_eff[i] = (i == 4) ? tc_exp[3] : bit'(in_en[i]);
            tc_exp[i] = en_eff[i] && ((in_up[i] && m_cnt[i] == m_mod[i] - 1) ||
                                      (!in_up[i] && m_cnt[i] == 0));
        end
        if (m_valid) begin
            for (int i = 0; i < N; i++) chk($sformatf("tc%0d", i), int'(o_tc[i]), int'(tc_exp[i]));
        end
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            int md;
            int lv;
            int nxt;
            md  = m_mod[i];
            lv  = int'(in_lv[i]) & m_mask[i];
            nxt = m_cnt[i] + (in_up[i] ? 1 : -1);
            if (!rst) begin
                m_cnt[i] = m_rv[i]; m_wrap[i] = 0; m_ovf[i] = 0;
            end else if (in_clr[i]) begin
                m_cnt[i] = 0; m_wrap[i] = 0; m_ovf[i] = 0;
            end else if (in_load[i]) begin
                if (lv < md) m_cnt[i] = lv;
                else begin m_cnt[i] = md - 1; m_ovf[i] = 1; end
                m_wrap[i] = 0;
            end else if (en_eff[i]) begin
                if (nxt < 0 || nxt >= md) begin
                    m_ovf[i] = 1;
                    if (in_sat[i]) m_wrap[i] = 0;
                    else begin m_cnt[i] = (nxt + md) % md; m_wrap[i] = 1; end
                end else begin
                    m_cnt[i] = nxt; m_wrap[i] = 0;
                end
            end else begin
                m_wrap[i] = 0;
            end
        end
        if (!rst) m_valid = 1'b1;
        #1;
        if (m_valid) begin
            for (int i = 0; i < N; i++) begin
                chk($sformatf("count%0d", i), int'(o_cnt[i]), m_cnt[i]);
                chk($sformatf("wrap%0d", i), int'(o_wrap[i]), int'(m_wrap[i]));
                chk($sformatf("ovf%0d", i), int'(o_ovf[i]), int'(m_ovf[i]));
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        set_all(0, 1, 0, 0, 0, 0);

        // Reset for two cycles
        tick();
        tick();
        chk("rst_a_count", int'(o_cnt[0]), 0);
        chk("rst_b_count", int'(o_cnt[1]), 5);
        chk("rst_a_ovf", int'(o_ovf[0]), 0);

        // Free-running up count with wrap
        rst = 1'b1;
        set_all(1, 1, 0, 0, 0, 0);
        for (int k = 1; k <= 70; k++) begin
            tick();
            if (k == 59) begin
                chk("up_59", int'(o_cnt[0]), 59);
                chk("up_tc59", int'(o_tc[0]), 1);
                chk("up_ovf_before", int'(o_ovf[0]), 0);
            end
            if (k == 60) begin
                chk("up_wrap0", int'(o_cnt[0]), 0);
                chk("up_wrap_pulse", int'(o_wrap[0]), 1);
                chk("up_ovf_after", int'(o_ovf[0]), 1);
            end
            if (k == 61) chk("up_wrap_clear", int'(o_wrap[0]), 0);
        end

        // Down count through zero
        set_all(0, 1, 0, 0, 1, 2);
        tick();
        chk("dn_load2", int'(o_cnt[0]), 2);
        set_all(1, 0, 0, 0, 0, 0);
        tick(); chk("dn_1", int'(o_cnt[0]), 1);
        tick(); chk("dn_0", int'(o_cnt[0]), 0);
        chk("dn_tc0", int'(o_tc[0]), 1);
        tick(); chk("dn_59", int'(o_cnt[0]), 59);
        chk("dn_wrap", int'(o_wrap[0]), 1);
        tick(); chk("dn_58", int'(o_cnt[0]), 58);
        chk("dn_wrap_clear", int'(o_wrap[0]), 0);

        // Saturate at the top
        set_all(0, 1, 0, 1, 0, 0);
        tick();
        set_all(0, 1, 1, 0, 1, 57);
        tick(); chk("sat_57", int'(o_cnt[0]), 57);
        set_all(1, 1, 1, 0, 0, 0);
        tick(); chk("sat_58", int'(o_cnt[0]), 58);
        tick(); chk("sat_59", int'(o_cnt[0]), 59);
        chk("sat_ovf_pre", int'(o_ovf[0]), 0);
        tick(); chk("sat_hold1", int'(o_cnt[0]), 59);
        chk("sat_ovf", int'(o_ovf[0]), 1);
        chk("sat_nowrap", int'(o_wrap[0]), 0);
        tick();
        tick(); chk("sat_hold3", int'(o_cnt[0]), 59);
        chk("sat_nowrap3", int'(o_wrap[0]), 0);

        // Priority and clamp
        set_all(1, 1, 0, 1, 1, 5);
        tick();
        chk("pri_count", int'(o_cnt[0]), 0);
        chk("pri_ovf", int'(o_ovf[0]), 0);
        set_all(0, 1, 0, 0, 1, 63);
        tick();
        chk("clamp_count", int'(o_cnt[0]), 59);
        chk("clamp_ovf", int'(o_ovf[0]), 1);
        chk("clamp_c_count", int'(o_cnt[2]), 9);
        set_all(0, 1, 0, 1, 0, 0);
        tick();
        chk("clr_ovf", int'(o_ovf[0]), 0);

        // Reset mid-count
        set_all(1, 1, 0, 0, 0, 0);
        repeat (30) tick();
        chk("mid_30", int'(o_cnt[0]), 30);
        chk("mid_b_ovf", int'(o_ovf[1]), 1);
        rst = 1'b0;
        tick();
        chk("mid_rst_a", int'(o_cnt[0]), 0);
        chk("mid_rst_b", int'(o_cnt[1]), 5);
        chk("mid_rst_b_ovf", int'(o_ovf[1]), 0);
        chk("mid_rst_wrap", int'(o_wrap[0]), 0);
        rst = 1'b1;

        // Narrow instances: mod16 and mod10 wraps
        set_all(0, 1, 0, 1, 0, 0);
        tick();
        set_all(1, 1, 0, 0, 0, 0);
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 9)  chk("m10_9", int'(o_cnt[2]), 9);
            if (k == 10) begin
                chk("m10_wrap0", int'(o_cnt[2]), 0);
                chk("m10_wrap", int'(o_wrap[2]), 1);
            end
            if (k == 15) chk("m16_15", int'(o_cnt[1]), 15);
            if (k == 16) begin
                chk("m16_wrap0", int'(o_cnt[1]), 0);
                chk("m16_wrap", int'(o_wrap[1]), 1);
            end
        end

        // Cascade: 3600 enabled cycles return the pair to (0,0)
        set_all(0, 1, 0, 1, 0, 0);
        tick();
        set_all(1, 1, 0, 0, 0, 0);
        for (int k = 1; k <= 3600; k++) begin
            tick();
            if (k == 60) begin
                chk("cas_60_lo", int'(o_cnt[3]), 0);
                chk("cas_60_hi", int'(o_cnt[4]), 1);
            end
            if (k == 3599) begin
                chk("cas_end_lo", int'(o_cnt[3]), 59);
                chk("cas_end_hi", int'(o_cnt[4]), 59);
            end
            if (k == 3600) begin
                chk("cas_roll_lo", int'(o_cnt[3]), 0);
                chk("cas_roll_hi", int'(o_cnt[4]), 0);
                chk("cas_roll_wrap", int'(o_wrap[4]), 1);
            end
        end

        // Random stimulus, model-checked every cycle
        repeat (400) begin
            for (int i = 0; i < N; i++) begin
                in_en[i]   = ($urandom_range(0, 3) != 0);
                in_up[i]   = 1'($urandom_range(0, 1));
                in_sat[i]  = ($urandom_range(0, 3) == 0);
                in_clr[i]  = ($urandom_range(0, 19) == 0);
                in_load[i] = ($urandom_range(0, 9) == 0);
                in_lv[i]   = 6'($urandom_range(0, 63));
            end
            rst = ($urandom_range(0, 49) != 0);
            tick();
        end
        rst = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
